// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral: SPI mode-0 target giving a host read/write access to NUM_REGS registers.
// All SPI pins are oversampled in the clk domain; frames are R/W bit, address, data, MSB first.
module spi_regfile_peripheral #(
    parameter int                NUM_REGS  = 5,
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int SW        = ADDR_W + DATA_W;
    localparam int CW        = $clog2(FRAME_LEN + 2);
    localparam logic [CW-1:0]     LEN    = CW'(FRAME_LEN);
    localparam logic [CW-1:0]     SAT    = CW'(FRAME_LEN + 1);
    localparam logic [CW-1:0]     ALAST  = CW'(ADDR_W);
    localparam logic [CW-1:0]     DLAST  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]     DSTART = CW'(ADDR_W + 1);
    localparam logic [ADDR_W:0]   NR     = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    state_t                     state_q, state_d;
    logic [2:0]                 sclk_s_q, ncs_s_q, copi_s_q;
    logic [1:0]                 fill_q, fill_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [SW-1:0]              sh_q, sh_d, sh_next;
    logic                       rw_q, rw_d;
    logic [ADDR_W-1:0]          addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]          shadow_q, shadow_d, rd_data;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic                       cipo_oe_q, cipo_oe_d, wr_strobe_q, wr_strobe_d, frame_err_q, frame_err_d;
    logic                       live, active, ncs_fall, ncs_rise, rise, fall, commit;

    // Edges are ignored until the chains hold real pin samples, so a reset with nCS low cannot fake a falling edge.
    assign live     = fill_q == 2'd3;
    assign active   = state_q != IDLE;
    assign ncs_fall = live & ~ncs_s_q[1] & ncs_s_q[2];
    assign ncs_rise = live & ncs_s_q[1] & ~ncs_s_q[2];
    assign rise     = live & active & ~ncs_rise & sclk_s_q[1] & ~sclk_s_q[2];
    assign fall     = live & active & ~ncs_rise & ~sclk_s_q[1] & sclk_s_q[2];
    assign sh_next  = {sh_q[SW-2:0], copi_s_q[2]};
    assign commit   = ncs_rise & active & (cnt_q == LEN) & rw_q & ({1'b0, addr_q} < NR);

    assign cipo      = shadow_q[DATA_W-1];
    assign cipo_oe   = cipo_oe_q;
    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ncs_rise)
            state_d = IDLE;
        else if (state_q == IDLE)
            state_d = ncs_fall ? CMD : IDLE;
        else if (rise && state_q == CMD)
            state_d = ADDR;
        else if (rise && state_q == ADDR && cnt_q == ALAST)
            state_d = DATA;
        else if (rise && state_q == DATA && cnt_q == DLAST)
            state_d = DONE;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (sh_next[ADDR_W-1:0] == ADDR_W'(i))
                rd_data = regs_q[i*DATA_W +: DATA_W];
    end

    always_comb begin
        fill_d      = live ? fill_q : fill_q + 2'd1;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        shadow_d    = shadow_q;
        regs_d      = regs_q;
        wr_addr_d   = commit ? addr_q : wr_addr_q;
        wr_strobe_d = commit;
        frame_err_d = ncs_rise & active & (cnt_q != LEN);
        cipo_oe_d   = state_d != IDLE;
        if (ncs_fall && !active) begin
            cnt_d    = '0;
            sh_d     = '0;
            rw_d     = 1'b0;
            shadow_d = '0;
        end
        if (ncs_rise)
            shadow_d = '0;
        if (rise) begin
            cnt_d = (cnt_q == SAT) ? SAT : cnt_q + 1'b1;
            sh_d  = (cnt_q < LEN) ? sh_next : sh_q;
            rw_d  = (state_q == CMD) ? copi_s_q[2] : rw_q;
            if (state_q == ADDR && cnt_q == ALAST) begin
                addr_d   = sh_next[ADDR_W-1:0];
                shadow_d = rw_q ? '0 : rd_data;
            end
        end
        // The MSB is already on cipo when the address latches, so only falls after a data rise advance it.
        if (fall && cnt_q > DSTART)
            shadow_d = shadow_q << 1;
        for (int i = 0; i < NUM_REGS; i++)
            if (commit && addr_q == ADDR_W'(i))
                regs_d[i*DATA_W +: DATA_W] = sh_q[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s_q    <= 3'b000;
            ncs_s_q     <= 3'b111;
            copi_s_q    <= 3'b000;
            fill_q      <= '0;
            cnt_q       <= '0;
            sh_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            shadow_q    <= '0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            wr_addr_q   <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            cipo_oe_q   <= 1'b0;
        end else begin
            sclk_s_q    <= {sclk_s_q[1:0], sclk};
            ncs_s_q     <= {ncs_s_q[1:0], ncs};
            copi_s_q    <= {copi_s_q[1:0], copi};
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            shadow_q    <= shadow_d;
            regs_q      <= regs_d;
            wr_addr_q   <= wr_addr_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            cipo_oe_q   <= cipo_oe_d;
        end
    end
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb_spi_regfile_peripheral: directed plus randomized SPI frames checked against a register-bank model.
module tb_spi_regfile_peripheral;
    localparam int NR = 5;
    localparam int AW = 7;
    localparam int DW = 8;

    logic            clk = 1'b0, rst = 1'b1, sclk = 1'b0, ncs = 1'b1, copi = 1'b0;
    logic            cipo, cipo_oe, wr_strobe, frame_err;
    logic [NR*DW-1:0] regs_out;
    logic [AW-1:0]   wr_addr;

    spi_regfile_peripheral #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo), .cipo_oe(cipo_oe),
        .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, strobe_cyc = 0, err_cyc = 0;
    logic [DW-1:0] model [NR];
    logic [AW-1:0] wa_exp = '0;
    logic [63:0]   samp;

    always @(posedge clk) begin
        if (wr_strobe) strobe_cyc <= strobe_cyc + 1;
        if (frame_err) err_cyc <= err_cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    // Host side of mode 0: data changes while sclk is low, cipo is sampled just before each rise.
    task automatic send(input logic [63:0] v, input int n, output logic [63:0] s);
        s = '0;
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            repeat (5) @(negedge clk);
            s[i] = cipo;
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input string tag, input logic [63:0] v, input int n, output logic [63:0] s);
        int s0, e0;
        logic rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic cm;
        s0 = strobe_cyc;
        e0 = err_cyc;
        ncs = 1'b0;
        repeat (5) @(negedge clk);
        chk({tag, " cipo_oe_low"}, cipo_oe, 1);
        send(v, n, s);
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        repeat (5) @(negedge clk);
        rw = v[15];
        a  = v[14:8];
        d  = v[7:0];
        cm = (n == 16) && rw && (a < NR);
        if (n == 16)
            chk({tag, " cipo_bits"}, s[15:0], rw ? 16'h0 : {8'h00, (a < NR) ? model[a] : 8'h00});
        if (cm) begin
            model[a] = d;
            wa_exp   = a;
        end
        chk({tag, " wr_strobe"}, 64'(strobe_cyc - s0), {63'b0, cm});
        chk({tag, " frame_err"}, 64'(err_cyc - e0), {63'b0, n != 16});
        chk({tag, " regs_out"}, regs_out, flat());
        chk({tag, " wr_addr"}, wr_addr, wa_exp);
        chk({tag, " cipo_oe_idle"}, cipo_oe, 0);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [63:0] wf(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {48'b0, rw, a, d};
    endfunction

    initial begin
        int s0, e0, n;
        logic [AW-1:0] a;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset regs_out", regs_out, flat());
        chk("reset cipo", cipo, 0);
        chk("reset cipo_oe", cipo_oe, 0);
        chk("reset wr_strobe", wr_strobe, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset wr_addr", wr_addr, 0);

        frame("wr2", wf(1, 7'h02, 8'hA5), 16, samp);
        chk("wr2 byte", regs_out[23:16], 8'hA5);
        frame("wr4", wf(1, 7'h04, 8'h3C), 16, samp);
        frame("rd4", wf(0, 7'h04, 8'h00), 16, samp);
        chk("rd4 serial", samp[7:0], 8'h3C);
        frame("abort11", wf(1, 7'h01, 8'h77) >> 5, 11, samp);
        frame("wr1", wf(1, 7'h01, 8'hFF), 16, samp);
        frame("wr_oob", wf(1, 7'h10, 8'h55), 16, samp);
        frame("rd_oob", wf(0, 7'h10, 8'h00), 16, samp);
        frame("len17", {wf(1, 7'h03, 8'h99), 1'b1}, 17, samp);
        frame("len0", 64'h0, 0, samp);

        s0 = strobe_cyc;
        e0 = err_cyc;
        ncs = 1'b0;
        repeat (5) @(negedge clk);
        send(wf(1, 7'h00, 8'hC3) >> 4, 12, samp);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        wa_exp = '0;
        repeat (4) @(negedge clk);
        chk("midrst regs_out", regs_out, flat());
        chk("midrst cipo_oe", cipo_oe, 0);
        send(64'hF, 4, samp);
        repeat (5) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst no_strobe", 64'(strobe_cyc - s0), 0);
        chk("midrst no_err", 64'(err_cyc - e0), 0);
        chk("midrst regs_kept", regs_out, flat());
        frame("after_rst", wf(1, 7'h00, 8'h5A), 16, samp);

        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(5, 127)) : AW'($urandom_range(0, 4));
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 18)) : 16;
            frame("rand", (n == 16) ? wf(1'($urandom), a, 8'($urandom)) : {$urandom, $urandom}, n, samp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
